mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_n_if.sv | 30 +++
 rtl/mux_arb_n.sv | 130 +++++++++++++
 tb/tb_mux_arb_n.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_arb_n_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_n_if
// Description : Channel-side and output-side handshake bundle for mux_arb_n.
// Revision    : 1.0
// ============================================================================
interface mux_arb_n_if #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = 2
);
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_n
// Description : N-channel arbitrating mux into a one-entry output register.
// Revision    : 1.0
// ============================================================================
module mux_arb_n #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux_arb_n_if.slave     bus,
  input  logic [1:0]     mode,
  input  logic [CW-1:0]  sel,
  output logic [15:0]    xfer_cnt
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]     xfer_cnt_q, xfer_cnt_d;

  logic            load_en;
  logic [NCH-1:0]  grant;
  logic [NCH-1:0]  ready;
  logic [CW-1:0]   g_idx;
  logic [DW-1:0]   g_data;
  logic            xfer;
  logic            rr_found;
  int              rr_idx;

  always_comb begin : p_grant
    grant    = '0;
    g_idx    = '0;
    g_data   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    case (mode)
      2'b00: begin
        // An out-of-range sel matches no channel, so it yields no grant.
        for (int k = 0; k < NCH; k++) begin
          if (sel == CW'(k) && bus.in_valid[k]) begin
            grant[k] = 1'b1;
            g_idx    = CW'(k);
            g_data   = bus.in_data[k*DW +: DW];
          end
        end
      end
      2'b01: begin
        for (int k = NCH - 1; k >= 0; k--) begin
          if (bus.in_valid[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            g_idx    = CW'(k);
            g_data   = bus.in_data[k*DW +: DW];
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < NCH; i++) begin
          rr_idx = int'(rr_ptr_q) + i;
          if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
          if (!rr_found && bus.in_valid[rr_idx]) begin
            rr_found       = 1'b1;
            grant[rr_idx]  = 1'b1;
            g_idx          = CW'(rr_idx);
            g_data         = bus.in_data[rr_idx*DW +: DW];
          end
        end
      end
      default: ;
    endcase
  end

  // Reset also forces in_ready low, independent of the clock.
  assign load_en = !rst && ((state_q == EMPTY) || bus.out_ready);
  assign ready   = grant & {NCH{load_en}};
  assign xfer    = |ready;

  always_comb begin : p_next
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (xfer) begin
      state_d    = FULL;
      out_data_d = g_data;
      out_ch_d   = g_idx;
      if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
      if (mode == 2'b10) begin
        rr_ptr_d = (g_idx == CW'(NCH - 1)) ? '0 : g_idx + CW'(1);
      end
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = (state_q == FULL);
  assign xfer_cnt      = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arb_n
// Description : Directed self-checking bench for mux_arb_n (NCH=4 and NCH=3).
// Revision    : 1.0
// ============================================================================
module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode, mode3;
  logic [1:0]  sel, sel3;
  logic [15:0] xfer_cnt, xfer_cnt3;
  int          n_vec = 0;
  int          n_err = 0;

  mux_arb_n_if #(.NCH(4), .DW(8), .CW(2)) bus  ();
  mux_arb_n_if #(.NCH(3), .DW(8), .CW(2)) bus3 ();

  mux_arb_n #(.NCH(4), .DW(8), .CW(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .mode(mode), .sel(sel), .xfer_cnt(xfer_cnt)
  );

  mux_arb_n #(.NCH(3), .DW(8), .CW(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .mode(mode3), .sel(sel3), .xfer_cnt(xfer_cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'b01; sel = 2'd0;
    bus.in_data  = '0; bus.in_valid  = 4'b1111; bus.out_ready  = 1'b1;
    mode3 = 2'b00; sel3 = 2'd0;
    bus3.in_data = '0; bus3.in_valid = 3'b000;  bus3.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_ch",    64'(bus.out_ch),    64'd0);
    check("rst_xfer_cnt",  64'(xfer_cnt),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);

    // Fixed-select on ch2
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b00; sel = 2'd2;
    bus.in_data = {8'h44, 8'hC3, 8'h22, 8'h11};
    bus.in_valid = 4'b1111;
    #1;
    check("fsel_in_ready", 64'(bus.in_ready), 64'b0100);
    tick();
    check("fsel_out_data",  64'(bus.out_data),  64'hC3);
    check("fsel_out_ch",    64'(bus.out_ch),    64'd2);
    check("fsel_out_valid", 64'(bus.out_valid), 64'd1);
    check("fsel_cnt",       64'(xfer_cnt),      64'd1);
    bus.in_valid = 4'b0000;
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_hold",  64'(bus.out_data),  64'hC3);
    check("drain_cnt",   64'(xfer_cnt),      64'd1);

    // Fixed priority
    mode = 2'b01; bus.in_valid = 4'b1010;
    #1;
    check("prio_ready_1010", 64'(bus.in_ready), 64'b0010);
    tick();
    check("prio_ch1",   64'(bus.out_ch),   64'd1);
    check("prio_data1", 64'(bus.out_data), 64'h22);
    bus.in_valid = 4'b1000;
    #1;
    check("prio_ready_1000", 64'(bus.in_ready), 64'b1000);
    tick();
    check("prio_ch3",  64'(bus.out_ch),   64'd3);
    check("prio_data3", 64'(bus.out_data), 64'h44);
    check("prio_cnt",  64'(xfer_cnt),     64'd3);
    bus.in_valid = 4'b0000;
    tick();

    // Reset while a beat is held
    mode = 2'b00; sel = 2'd0;
    bus.in_data = {8'h44, 8'hC3, 8'h22, 8'h5A};
    bus.in_valid = 4'b0001;
    tick();
    bus.in_valid = 4'b0000; bus.out_ready = 1'b0;
    check("beat_valid", 64'(bus.out_valid), 64'd1);
    check("beat_data",  64'(bus.out_data),  64'h5A);
    check("beat_cnt",   64'(xfer_cnt),      64'd4);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_data",  64'(bus.out_data),  64'd0);
    check("async_rst_cnt",   64'(xfer_cnt),      64'd0);

    // Round-robin, all channels requesting
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b10; bus.out_ready = 1'b1;
    bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid = 4'b1111;
    tick(); check("rr_ch_0", 64'(bus.out_ch), 64'd0); check("rr_d_0", 64'(bus.out_data), 64'hA0);
    tick(); check("rr_ch_1", 64'(bus.out_ch), 64'd1); check("rr_d_1", 64'(bus.out_data), 64'hA1);
    tick(); check("rr_ch_2", 64'(bus.out_ch), 64'd2); check("rr_d_2", 64'(bus.out_data), 64'hA2);
    tick(); check("rr_ch_3", 64'(bus.out_ch), 64'd3); check("rr_d_3", 64'(bus.out_data), 64'hA3);
    tick(); check("rr_ch_4", 64'(bus.out_ch), 64'd0); check("rr_d_4", 64'(bus.out_data), 64'hA0);
    check("rr_cnt", 64'(xfer_cnt), 64'd5);

    // Backpressure, then drain-and-refill without a bubble
    bus.out_ready = 1'b0; mode = 2'b01; bus.in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_data",  64'(bus.out_data),  64'hA0);
      check("bp_ch",    64'(bus.out_ch),    64'd0);
    end
    check("bp_cnt", 64'(xfer_cnt), 64'd5);
    bus.out_ready = 1'b1;
    #1;
    check("refill_ready", 64'(bus.in_ready), 64'b0010);
    tick();
    check("refill_data", 64'(bus.out_data), 64'hA1);
    check("refill_ch",   64'(bus.out_ch),   64'd1);
    check("refill_cnt",  64'(xfer_cnt),     64'd6);
    tick();
    check("stream_valid", 64'(bus.out_valid), 64'd1);
    check("stream_cnt",   64'(xfer_cnt),      64'd7);

    // Hold mode: no grants, register still drains
    mode = 2'b11; bus.in_valid = 4'b1111;
    #1;
    check("hold_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("hold_valid", 64'(bus.out_valid), 64'd0);
    check("hold_cnt",   64'(xfer_cnt),      64'd7);
    check("hold_data",  64'(bus.out_data),  64'hA1);

    // NCH=3: sel=3 is out of range
    bus.in_valid = 4'b0000;
    bus3.in_data = {8'h33, 8'h32, 8'h31};
    bus3.in_valid = 3'b111; sel3 = 2'd3;
    #1;
    check("n3_sel3_ready", 64'(bus3.in_ready), 64'd0);
    tick();
    check("n3_sel3_valid", 64'(bus3.out_valid), 64'd0);
    check("n3_sel3_cnt",   64'(xfer_cnt3),      64'd0);
    sel3 = 2'd2;
    #1;
    check("n3_sel2_ready", 64'(bus3.in_ready), 64'b100);
    tick();
    check("n3_sel2_ch",   64'(bus3.out_ch),   64'd2);
    check("n3_sel2_data", 64'(bus3.out_data), 64'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
